// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-bus bundle for mem_port_arbiter.
// master = arbiter view, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              bus_req;
    logic              bus_we;
    logic [BE_W-1:0]   bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  bus_ack, bus_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output stall_if, stall_mem
    );

    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output bus_ack, bus_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for the single-port unified memory.
// Define ARB_STARVE_GUARD_EN to bound MEM streaks while IF waits.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_MEM_STREAK = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master arb
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              pick_if;
    logic              pick_mem;
    logic              if_first;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    if (MAX_MEM_STREAK < 1) begin : g_bad_streak
        $error("MAX_MEM_STREAK must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_MEM_STREAK);

    logic [CNT_W-1:0] streak;

    // Counts MEM wins that happened while IF was waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (pick_if) begin
            streak <= '0;
        end else if (pick_mem) begin
            if (!arb.if_req)
                streak <= '0;
            else if (streak != STREAK_MAX)
                streak <= streak + 1'b1;
        end
    end

    assign if_first = arb.if_req && (streak == STREAK_MAX);
`else
    assign if_first = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // MEM holds the older instruction, so it wins unless the guard trips.
    always_comb begin
        state_nx = state;
        pick_if  = 1'b0;
        pick_mem = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb.mem_req && !if_first) begin
                    pick_mem = 1'b1;
                    state_nx = BUSY_MEM;
                end else if (arb.if_req) begin
                    pick_if  = 1'b1;
                    state_nx = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (arb.bus_ack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (pick_mem) begin
            we_q    <= arb.mem_we;
            be_q    <= arb.mem_be;
            addr_q  <= arb.mem_addr;
            wdata_q <= arb.mem_wdata;
        end else if (pick_if) begin
            we_q    <= 1'b0;
            be_q    <= '1;
            addr_q  <= arb.if_addr;
            wdata_q <= '0;
        end
    end

    assign arb.bus_req   = (state != IDLE);
    assign arb.bus_we    = we_q;
    assign arb.bus_be    = be_q;
    assign arb.bus_addr  = addr_q;
    assign arb.bus_wdata = wdata_q;

    assign arb.if_gnt  = pick_if;
    assign arb.mem_gnt = pick_mem;

    assign arb.if_rvalid  = (state == BUSY_IF) && arb.bus_ack;
    assign arb.mem_rvalid = (state == BUSY_MEM) && arb.bus_ack;

    assign arb.if_rdata  = arb.if_rvalid ? arb.bus_rdata : '0;
    assign arb.mem_rdata = (arb.mem_rvalid && !we_q) ? arb.bus_rdata : '0;

    assign arb.stall_if  = arb.if_req && !arb.if_rvalid;
    assign arb.stall_mem = arb.mem_req && !arb.mem_rvalid;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. A small FSM grants one requester at a time, registers its command onto the memory bus, and waits for the bus acknowledge. It then returns completion and read data to the owner. It drives per-stage stall flags to the pipeline, alongside the existing data-hazard stall logic.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width; byte-enable width is DATA_W/8
MAX_MEM_STREAK, 4, consecutive MEM grants allowed while IF is pending (used only with ARB_STARVE_GUARD_EN)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_rvalid
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  1-cycle pulse: fetch accepted
if_rvalid  out  1  fetch complete
if_rdata  out  DATA_W  fetched instruction
mem_req  in  1  data request; held until mem_rvalid
mem_we  in  1  1 = store
mem_be  in  DATA_W/8  store byte enables
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_gnt  out  1  1-cycle pulse: data access accepted
mem_rvalid  out  1  data access complete
mem_rdata  out  DATA_W  load data
bus_req  out  1  memory command valid
bus_we  out  1  memory write
bus_be  out  DATA_W/8  memory byte enables
bus_addr  out  ADDR_W  memory address
bus_wdata  out  DATA_W  memory write data
bus_ack  in  1  memory completes the current command this cycle
bus_rdata  in  DATA_W  memory read data, valid with bus_ack
stall_if  out  1  IF must hold
stall_mem  out  1  MEM (and older stages) must hold

Behaviour:
- Reset state and outputs:
  - FSM in IDLE.
  - bus_req, bus_we, bus_be, bus_addr and bus_wdata all 0.
  - All gnt and rvalid outputs 0; rdata outputs 0.
  - Streak counter 0.
- FSM states: IDLE, BUSY_IF, BUSY_MEM.
- IDLE, cycle N:
  - If any request is pending, select a winner. mem_req has priority over if_req (MEM holds the older instruction).
  - Pulse the winner's gnt combinationally in cycle N.
  - Register the winner's command into the bus_* registers at edge N.
  - Move to BUSY_IF or BUSY_MEM.
  - IF commands force bus_we=0 and bus_be=all ones, and set bus_wdata=0.
- BUSY_x:
  - bus_req=1 and the bus_* registers are held constant until bus_ack.
  - In the bus_ack cycle M: the owner's rvalid=1, combinationally in cycle M. rdata = bus_rdata for reads; for stores rdata=0 and rvalid still signals completion.
  - Go to IDLE at edge M; a new grant is possible in cycle M+1.
  - Minimum occupancy is 2 cycles per access: grant cycle plus ack cycle.
- bus_ack while in IDLE is ignored.
- Non-owner rvalid is always 0; non-owner rdata is 0.
- Stall flags: stall_if = if_req & ~if_rvalid; stall_mem = mem_req & ~mem_rvalid. Both are combinational, with no added latency.
- Requester protocol:
  - Requesters hold req and payload stable from assertion through their rvalid cycle.
  - A req seen in the cycle after rvalid is a new request.
  - Dropping req mid-transaction is illegal. The arbiter completes the transaction regardless and still pulses rvalid.
- Simultaneous events: bus_ack and a new req in the same cycle produce no grant in that cycle; the request is granted in the next cycle.
- Reset mid-operation: asynchronous reset immediately drops bus_req and returns to IDLE. The outstanding transaction is abandoned, and the memory model must discard it.
- Read data is not registered; the total path bus_rdata -> if_rdata/mem_rdata is combinational.

Optional Feature:
ARB_STARVE_GUARD_EN:
- Defined:
  - A saturating counter (width clog2(MAX_MEM_STREAK+1)) increments on each MEM grant issued while if_req=1.
  - It clears on any IF grant, and on a MEM grant with if_req=0.
  - When the counter equals MAX_MEM_STREAK and both requests are pending in IDLE, IF wins.
- Undefined: strict MEM priority and no counter logic; IF can starve indefinitely under continuous mem_req.

Test Plan:
1. IF-only read: if_req=1, if_addr=0x100, bus_ack in cycle 3 with bus_rdata=0x00500093.
   - Cycle 0: if_gnt=1.
   - Cycles 1-3: bus_req=1, bus_addr=0x100, bus_be=0xF.
   - Cycle 3: if_rvalid=1, if_rdata=0x00500093.
   - stall_if=1 in cycles 0-2 and 0 in cycle 3.
2. Simultaneous if_req and mem_req (load at 0x2000) in cycle 0, ack one cycle after each grant.
   - Cycle 0: mem_gnt=1.
   - Cycle 1: mem_rvalid=1.
   - Cycle 2: if_gnt=1.
   - Cycle 3: if_rvalid=1.
   - stall_if=1 in cycles 0-2.
3. Store: mem_we=1, mem_be=0x3, mem_addr=0x2000, mem_wdata=0xDEADBEEF.
   - bus_we=1, bus_be=0x3, bus_wdata=0xDEADBEEF until ack.
   - On ack: mem_rvalid=1, mem_rdata=0.
4. Zero-wait bus (bus_ack=1 constantly) with back-to-back IF requests: grants in cycles 0, 2, 4 and if_rvalid in cycles 1, 3, 5.
5. Reset asserted in cycle 2 of a pending fetch: bus_req=0 in the same cycle, with no clock edge required. After deassertion, a new if_req is granted on the first cycle.
6. Continuous mem_req and if_req with MAX_MEM_STREAK=4:
   - With ARB_STARVE_GUARD_EN: 4 MEM grants, then an IF grant, then the pattern repeats.
   - Without it: if_gnt stays 0 for 50 cycles.
